// File: rtl/vx_cache_fill_ctrl_if.sv
// Bank-side bundle of the fill controller: memory responses, miss credit,
// fill request/grant towards the bank arbiter and the MSHR replay handshake.
interface vx_cache_fill_ctrl_if #(
  parameter int LINE_SIZE = 16,
  parameter int MSHR_SIZE = 4
);
  localparam int DATA_W = LINE_SIZE * 8;
  localparam int TAG_W  = (MSHR_SIZE > 1) ? $clog2(MSHR_SIZE) : 1;

  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic [TAG_W-1:0]  mem_rsp_tag;
  logic              mem_rsp_ready;
  logic              mem_req_fire;
  logic              mem_req_credit;
  logic              fill_req_valid;
  logic [TAG_W-1:0]  fill_req_id;
  logic [DATA_W-1:0] fill_req_data;
  logic              fill_req_ready;
  logic              fill_valid;
  logic [TAG_W-1:0]  fill_id;
  logic              mshr_dequeue_valid;
  logic              busy;

  // master is the bank environment (memory, arbiter, MSHR); slave is the controller
  modport master (
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag, mem_req_fire,
           fill_req_ready, mshr_dequeue_valid,
    input  mem_rsp_ready, mem_req_credit, fill_req_valid, fill_req_id,
           fill_req_data, fill_valid, fill_id, busy
  );

  modport slave (
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag, mem_req_fire,
           fill_req_ready, mshr_dequeue_valid,
    output mem_rsp_ready, mem_req_credit, fill_req_valid, fill_req_id,
           fill_req_data, fill_valid, fill_id, busy
  );
endinterface

// File: rtl/vx_cache_fill_ctrl.sv
// Per-bank memory-response front end: buffers line fills in arrival order, hands
// them to the bank arbiter one at a time and paces them on the MSHR replay chain.

module vx_cache_fill_ctrl_chk #(
  parameter int CNT_W       = 3,
  parameter int MAX_PENDING = 4
) (
  input logic             clk,
  input logic             reset,
  input logic             arm_s,
  input logic             dequeue_valid_s,
  input logic             fire_s,
  input logic             fill_s,
  input logic [CNT_W-1:0] pend_s
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  // Protocol checks: replay must start in the ARM cycle, and the miss counter
  // must never wrap (a fill in the same cycle absorbs a fire at the limit).
  always_ff @(posedge clk) begin
    arm_has_replay: assert (!reset || !arm_s || dequeue_valid_s);
    no_overflow:    assert (!reset || !(fire_s && !fill_s && (pend_s == CNT_MAX)));
    no_underflow:   assert (!reset || !(fill_s && (pend_s == {CNT_W{1'b0}})));
  end
endmodule

module vx_cache_fill_ctrl #(
  parameter int LINE_SIZE       = 16,
  parameter int MSHR_SIZE       = 4,
  parameter int FILL_QUEUE_SIZE = 2,
  parameter int MAX_PENDING     = 4
) (
  input logic                 clk,
  input logic                 reset,
  vx_cache_fill_ctrl_if.slave bus
);
  localparam int DATA_W = LINE_SIZE * 8;
  localparam int TAG_W  = (MSHR_SIZE > 1) ? $clog2(MSHR_SIZE) : 1;
  localparam int PTR_W  = (FILL_QUEUE_SIZE > 1) ? $clog2(FILL_QUEUE_SIZE) : 1;
  localparam int OCC_W  = $clog2(FILL_QUEUE_SIZE + 1);
  localparam int CNT_W  = $clog2(MAX_PENDING + 1);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FILL_QUEUE_SIZE);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_mem_q  [FILL_QUEUE_SIZE];
  logic [DATA_W-1:0] data_mem_q [FILL_QUEUE_SIZE];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  pend_q, pend_d;

  logic empty_s;
  logic full_s;
  logic head_valid_s;
  logic push_s;
  logic pop_s;

  // Queue flags, handshakes and next-state for pointers, occupancy, counter and FSM.
  always_comb begin
    empty_s      = (occ_q == {OCC_W{1'b0}});
    full_s       = (occ_q == OCC_FULL);
    head_valid_s = (state_q == ST_IDLE) && !empty_s;
    push_s       = bus.mem_rsp_valid && !full_s;
    pop_s        = head_valid_s && bus.fill_req_ready;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    // a fill retires one outstanding miss; a fire in the same cycle replaces it
    case ({bus.mem_req_fire, pop_s})
      2'b10:   pend_d = pend_q + CNT_W'(1);
      2'b01:   pend_d = pend_q - CNT_W'(1);
      default: pend_d = pend_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM:   state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.mshr_dequeue_valid) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Response FIFO storage and pointers; reset discards anything queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
      for (int i = 0; i < FILL_QUEUE_SIZE; i++) begin
        tag_mem_q[i]  <= {TAG_W{1'b0}};
        data_mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push_s) begin
        tag_mem_q[wr_ptr_q]  <= bus.mem_rsp_tag;
        data_mem_q[wr_ptr_q] <= bus.mem_rsp_data;
      end
    end
  end

  // Outstanding memory read counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= {CNT_W{1'b0}};
    end else begin
      pend_q <= pend_d;
    end
  end

  // Fill pacing FSM: IDLE offers the head, ARM/DRAIN hold off until replay ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.mem_rsp_ready  = !full_s;
  assign bus.mem_req_credit = (pend_q < CNT_MAX);
  assign bus.fill_req_valid = head_valid_s;
  assign bus.fill_req_id    = tag_mem_q[rd_ptr_q];
  assign bus.fill_req_data  = data_mem_q[rd_ptr_q];
  assign bus.fill_valid     = pop_s;
  assign bus.fill_id        = tag_mem_q[rd_ptr_q];
  assign bus.busy           = !empty_s || (state_q != ST_IDLE);

  vx_cache_fill_ctrl_chk #(
    .CNT_W       (CNT_W),
    .MAX_PENDING (MAX_PENDING)
  ) u_chk (
    .clk             (clk),
    .reset           (reset),
    .arm_s           (state_q == ST_ARM),
    .dequeue_valid_s (bus.mshr_dequeue_valid),
    .fire_s          (bus.mem_req_fire),
    .fill_s          (pop_s),
    .pend_s          (pend_q)
  );
endmodule

// File: tb/tb_vx_cache_fill_ctrl.sv
// Self-checking bench for vx_cache_fill_ctrl: directed scenarios plus randomized
// traffic compared each cycle against a queue/counter reference model.
module tb_vx_cache_fill_ctrl;
  localparam int LS = 16;
  localparam int MS = 4;
  localparam int FQ = 2;
  localparam int MP = 4;
  localparam int DW = LS * 8;
  localparam int TW = 2;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  logic clk;
  logic reset;

  vx_cache_fill_ctrl_if #(.LINE_SIZE(LS), .MSHR_SIZE(MS)) bus ();

  vx_cache_fill_ctrl #(
    .LINE_SIZE(LS), .MSHR_SIZE(MS), .FILL_QUEUE_SIZE(FQ), .MAX_PENDING(MP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: queued fills, outstanding misses, and the replay hold-off
  ent_t          mq[$];
  int            pend;
  bit            blocked;
  int            age;
  int            cyc;
  int            n_chk;
  int            n_fail;
  bit            last_acc;
  logic [TW-1:0] dut_ids[$];
  logic [DW-1:0] dut_data[$];
  int            dut_cyc[$];

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    mq.delete();
    pend = 0; blocked = 1'b0; age = 0; last_acc = 1'b0;
    dut_ids.delete(); dut_data.delete(); dut_cyc.delete();
  endtask

  task automatic drive_idle();
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_tag = '0; bus.mem_rsp_data = '0;
    bus.mem_req_fire = 1'b0; bus.fill_req_ready = 1'b0; bus.mshr_dequeue_valid = 1'b0;
  endtask

  // One clock cycle starting at a negedge: drive, compare against model, advance model.
  task automatic step(input bit rv, input logic [TW-1:0] t, input logic [DW-1:0] d,
                      input bit fire, input bit rdy, input bit dv);
    bit   exp_v, acc, gnt, arm;
    ent_t e;
    arm = blocked && (age == 0);
    bus.mem_rsp_valid = rv; bus.mem_rsp_tag = t; bus.mem_rsp_data = d;
    bus.mem_req_fire = fire; bus.fill_req_ready = rdy;
    bus.mshr_dequeue_valid = dv || arm;
    #1;
    exp_v = (mq.size() != 0) && !blocked;
    n_chk++; if (bus.fill_req_valid !== exp_v) begin n_fail++;
      $display("FAIL fill_req_valid cyc %0d: got %b expected %b", cyc, bus.fill_req_valid, exp_v); end
    n_chk++; if (bus.fill_valid !== (exp_v && rdy)) begin n_fail++;
      $display("FAIL fill_valid cyc %0d: got %b expected %b", cyc, bus.fill_valid, exp_v && rdy); end
    n_chk++; if (bus.mem_rsp_ready !== (mq.size() < FQ)) begin n_fail++;
      $display("FAIL mem_rsp_ready cyc %0d: got %b expected %b", cyc, bus.mem_rsp_ready, mq.size() < FQ); end
    n_chk++; if (bus.mem_req_credit !== (pend < MP)) begin n_fail++;
      $display("FAIL mem_req_credit cyc %0d: got %b expected %b", cyc, bus.mem_req_credit, pend < MP); end
    n_chk++; if (bus.busy !== ((mq.size() != 0) || blocked)) begin n_fail++;
      $display("FAIL busy cyc %0d: got %b expected %b", cyc, bus.busy, (mq.size() != 0) || blocked); end
    if (exp_v) begin
      e = mq[0];
      n_chk++; if (bus.fill_req_id !== e.tag || bus.fill_id !== e.tag) begin n_fail++;
        $display("FAIL fill_id cyc %0d: got %0d/%0d expected %0d", cyc, bus.fill_req_id, bus.fill_id, e.tag); end
      n_chk++; if (bus.fill_req_data !== e.data) begin n_fail++;
        $display("FAIL fill_req_data cyc %0d: got %h expected %h", cyc, bus.fill_req_data, e.data); end
    end
    if (bus.fill_valid === 1'b1) begin
      dut_ids.push_back(bus.fill_id); dut_data.push_back(bus.fill_req_data); dut_cyc.push_back(cyc);
    end
    acc = rv && (mq.size() < FQ);
    gnt = exp_v && rdy;
    @(posedge clk);
    if (gnt) begin
      e = mq.pop_front();
      pend--; blocked = 1'b1; age = 0;
    end else if (blocked) begin
      age++;
      if (age >= 2 && !(dv || arm)) blocked = 1'b0;
    end
    if (acc) begin e.tag = t; e.data = d; mq.push_back(e); end
    if (fire) pend++;
    last_acc = acc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1; drive_idle();
    #2 reset = 1'b0;
    #1;
    n_chk++; if (bus.mem_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rsp_ready: got %b expected 1", bus.mem_rsp_ready); end
    n_chk++; if (bus.fill_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fill_req_valid: got %b expected 0", bus.fill_req_valid); end
    n_chk++; if (bus.fill_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fill_valid: got %b expected 0", bus.fill_valid); end
    n_chk++; if (bus.mem_req_credit !== 1'b1) begin n_fail++; $display("FAIL reset_credit: got %b expected 1", bus.mem_req_credit); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_fill();
    logic [DW-1:0] da5, d2;
    apply_reset();
    da5 = {LS{8'hA5}};
    d2  = rand_line();
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd2, da5, 1'b0, 1'b0, 1'b0);
    n_chk++; if (bus.fill_req_valid !== 1'b1 || bus.fill_req_id !== 2'd2) begin n_fail++;
      $display("FAIL single_next_cycle: got valid %b id %0d expected valid 1 id 2", bus.fill_req_valid, bus.fill_req_id); end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'd1, d2, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (bus.fill_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL single_held_in_drain: got %b expected 0", bus.fill_req_valid); end
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (bus.fill_req_valid !== 1'b1 || bus.fill_req_id !== 2'd1) begin n_fail++;
      $display("FAIL single_eligible_after_drain: got valid %b id %0d expected valid 1 id 1", bus.fill_req_valid, bus.fill_req_id); end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (bus.busy !== 1'b0 || bus.mem_req_credit !== 1'b1) begin n_fail++;
      $display("FAIL single_end_state: got busy %b credit %b expected busy 0 credit 1", bus.busy, bus.mem_req_credit); end
    n_chk++; if (dut_ids.size() != 2 || dut_data.size() != 2 || dut_data[0] !== da5) begin n_fail++;
      $display("FAIL single_fill_count: got %0d fills expected 2 with first data a5..", dut_ids.size()); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d1, d3;
    apply_reset();
    d1 = rand_line(); d3 = rand_line();
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd1, d1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd3, d3, 1'b0, 1'b0, 1'b0);
    n_chk++; if (bus.mem_rsp_ready !== 1'b0) begin n_fail++;
      $display("FAIL bp_rsp_ready_full: got %b expected 0", bus.mem_rsp_ready); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      n_chk++; if (bus.fill_req_valid !== 1'b1 || bus.fill_req_id !== 2'd1 || bus.fill_req_data !== d1) begin n_fail++;
        $display("FAIL bp_head_stable: got valid %b id %0d expected valid 1 id 1", bus.fill_req_valid, bus.fill_req_id); end
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    n_chk++; if (dut_ids.size() != 2) begin n_fail++;
      $display("FAIL bp_fill_count: got %0d expected 2", dut_ids.size()); end
    else begin
      n_chk++; if (dut_ids[0] !== 2'd1 || dut_ids[1] !== 2'd3) begin n_fail++;
        $display("FAIL bp_order: got %0d,%0d expected 1,3", dut_ids[0], dut_ids[1]); end
      n_chk++; if (dut_cyc[1] - dut_cyc[0] != 3) begin n_fail++;
        $display("FAIL bp_spacing: got %0d expected 3", dut_cyc[1] - dut_cyc[0]); end
    end
  endtask

  task automatic test_credit_limit();
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    n_chk++; if (bus.mem_req_credit !== 1'b0) begin n_fail++;
      $display("FAIL credit_at_limit: got %b expected 0", bus.mem_req_credit); end
    step(1'b1, 2'd0, rand_line(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1, rand_line(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    n_chk++; if (bus.mem_req_credit !== 1'b0) begin n_fail++;
      $display("FAIL credit_fill_plus_fire: got %b expected 0", bus.mem_req_credit); end
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    n_chk++; if (bus.mem_req_credit !== 1'b1) begin n_fail++;
      $display("FAIL credit_lone_fill: got %b expected 1", bus.mem_req_credit); end
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_replay_gating();
    apply_reset();
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd2, rand_line(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, rand_line(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      n_chk++; if (bus.fill_req_valid !== 1'b0) begin n_fail++;
        $display("FAIL gate_hold_%0d: got %b expected 0", i, bus.fill_req_valid); end
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    n_chk++; if (bus.fill_req_valid !== 1'b1 || bus.fill_req_id !== 2'd0) begin n_fail++;
      $display("FAIL gate_release: got valid %b id %0d expected valid 1 id 0", bus.fill_req_valid, bus.fill_req_id); end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    n_chk++; if (dut_ids.size() != 2 || dut_cyc[1] - dut_cyc[0] != 7) begin n_fail++;
      $display("FAIL gate_spacing: got %0d fills expected 2 spaced 7", dut_ids.size()); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] wd[9];
    int fired, pushed, idx;
    bit f;
    apply_reset();
    for (int i = 0; i < 9; i++) wd[i] = rand_line();
    fired = 0; pushed = 0;
    for (int c = 0; c < 400 && dut_ids.size() < 9; c++) begin
      f   = (fired < 9) && (pend < MP);
      idx = (pushed < 9) ? pushed : 0;
      step(pushed < fired, TW'(idx % 4), wd[idx], f,
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      if (last_acc) pushed++;
      if (f) fired++;
    end
    for (int c = 0; c < 10; c++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    n_chk++; if (dut_ids.size() != 9) begin n_fail++;
      $display("FAIL wrap_fill_count: got %0d expected 9", dut_ids.size()); end
    else begin
      for (int i = 0; i < 9; i++) begin
        n_chk++; if (dut_ids[i] !== TW'(i % 4) || dut_data[i] !== wd[i]) begin n_fail++;
          $display("FAIL wrap_order_%0d: got id %0d expected %0d", i, dut_ids[i], i % 4); end
      end
    end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL wrap_busy_end: got %b expected 0", bus.busy); end
  endtask

  task automatic test_random();
    int infl;
    bit sv, f;
    logic [TW-1:0] st;
    logic [DW-1:0] sd;
    apply_reset();
    infl = 0; sv = 1'b0; st = '0; sd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!sv && infl > 0 && ($urandom_range(0, 1) != 0)) begin
        sv = 1'b1; st = TW'($urandom_range(0, MS - 1)); sd = rand_line();
      end
      f = (pend < MP) && ($urandom_range(0, 1) != 0);
      step(sv, st, sd, f, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0));
      if (last_acc) begin sv = 1'b0; infl--; end
      if (f) infl++;
    end
    for (int c = 0; c < 20; c++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL random_busy_end: got %b expected 0", bus.busy); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd3, rand_line(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, rand_line(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    n_chk++; if (bus.busy !== 1'b1 || bus.mem_req_credit !== 1'b1) begin n_fail++;
      $display("FAIL areset_pre_state: got busy %b expected 1", bus.busy); end
    #2 reset = 1'b0;
    #1;
    n_chk++; if (bus.fill_req_valid !== 1'b0 || bus.fill_valid !== 1'b0) begin n_fail++;
      $display("FAIL areset_valid: got %b/%b expected 0/0", bus.fill_req_valid, bus.fill_valid); end
    n_chk++; if (bus.mem_rsp_ready !== 1'b1 || bus.mem_req_credit !== 1'b1 || bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL areset_flags: got ready %b credit %b busy %b expected 1 1 0",
               bus.mem_rsp_ready, bus.mem_req_credit, bus.busy); end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    n_chk++; if (dut_ids.size() != 0 || bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL areset_no_fill_after: got %0d fills busy %b expected 0 fills busy 0", dut_ids.size(), bus.busy); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    model_clear();
    test_reset();
    test_single_fill();
    test_backpressure();
    test_credit_limit();
    test_replay_gating();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
